// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern pipeline: timing defaults,
// pattern mode encodings and colour constants.
package vga_pkg;

  localparam int H_ACTIVE_DEF  = 800;
  localparam int V_ACTIVE_DEF  = 600;
  localparam int BAR_WIDTH_DEF = 100;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_GRID    = 2'd2,
    MODE_RAMP    = 2'd3
  } mode_e;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_WHITE = 3'b111;

  // Idle value of the {hsync, vsync, blank} alignment line.
  localparam logic [2:0] SYNC_BLANK_IDLE = 3'b111;

endpackage

// File: rtl/test_pattern_gen_if.sv
// Pixel output bus of the test-pattern generator: colour, re-aligned syncs,
// pixel coordinate and status.
interface test_pattern_gen_if;

  logic       red_out;
  logic       green_out;
  logic       blue_out;
  logic       hsync_out;
  logic       vsync_out;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [1:0] mode_out;
  logic [7:0] frame_count_out;

  modport master (
    output red_out, green_out, blue_out, hsync_out, vsync_out,
    output x_out, y_out, mode_out, frame_count_out
  );

  modport slave (
    input red_out, green_out, blue_out, hsync_out, vsync_out,
    input x_out, y_out, mode_out, frame_count_out
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that keeps sync and blank aligned with the pixel
// pipeline; every stage resets to a parameterised idle value.
module vga_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/test_pattern_gen.sv
// Test-pattern generator: derives pixel coordinates from upstream blanking,
// renders one of four patterns and re-aligns the syncs to the pixel data.
module test_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int BAR_WIDTH = BAR_WIDTH_DEF
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblank_in,
  input  logic               vblank_in,
  input  logic               mode_next,
  input  logic               mode_load,
  input  logic [1:0]         mode_sel,
  test_pattern_gen_if.master vid
);

  localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [6:0] BAR_LAST = 7'(BAR_WIDTH - 1);

  logic       blank, hblank_rise, vblank_rise;
  logic       hblank_prev_q, vblank_prev_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [6:0] bar_cnt_q, bar_cnt_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  mode_e      mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [2:0] pix_bar_q, pix_bar_d;
  mode_e      pix_mode_q;
  logic [2:0] rgb_q, rgb_d;
  logic [9:0] x_out_q, y_out_q;
  logic       hsync_dly, vsync_dly, blank_dly;

  assign blank       = hblank_in | vblank_in;
  assign hblank_rise = hblank_in & ~hblank_prev_q;
  assign vblank_rise = vblank_in & ~vblank_prev_q;

  // x/bar counters hold the position of the next active pixel, so they sit at
  // zero throughout blanking and the first active pixel needs no special case.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (blank) begin
      x_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else begin
      if (x_q != X_LAST) x_d = x_q + 10'd1;
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 7'd1;
      end
    end
    if (vblank_in) y_d = '0;
    else if (hblank_rise && y_q != Y_LAST) y_d = y_q + 10'd1;
  end

  // A request on the frame-boundary cycle lands in pending after the old
  // pending value has been applied.
  always_comb begin
    mode_d       = mode_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    frame_cnt_d  = frame_cnt_q;
    if (vblank_rise) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (pend_valid_q) begin
        mode_d       = pend_mode_q;
        pend_valid_d = 1'b0;
      end
    end
    if (mode_load) begin
      pend_mode_d  = mode_e'(mode_sel);
      pend_valid_d = 1'b1;
    end else if (mode_next) begin
      pend_mode_d  = mode_e'(mode_q + 2'd1);
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    pix_x_d   = blank ? '0 : x_q;
    pix_y_d   = y_q;
    pix_bar_d = blank ? '0 : bar_idx_q;
  end

  always_comb begin
    rgb_d = RGB_BLACK;
    case (pix_mode_q)
      MODE_BARS:    rgb_d = pix_bar_q;
      MODE_CHECKER: rgb_d = {3{pix_x_q[5] ^ pix_y_q[5]}};
      MODE_GRID:    rgb_d = (pix_x_q[4:0] == 5'd0 || pix_y_q[4:0] == 5'd0) ? RGB_WHITE : RGB_BLACK;
      MODE_RAMP:    rgb_d = pix_x_q[9:7] ^ pix_y_q[9:7];
      default:      rgb_d = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      hblank_prev_q <= 1'b1;
      vblank_prev_q <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      mode_q        <= MODE_BARS;
      pend_mode_q   <= MODE_BARS;
      pend_valid_q  <= 1'b0;
      frame_cnt_q   <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_bar_q     <= '0;
      pix_mode_q    <= MODE_BARS;
      rgb_q         <= RGB_BLACK;
      x_out_q       <= '0;
      y_out_q       <= '0;
    end else begin
      hblank_prev_q <= hblank_in;
      vblank_prev_q <= vblank_in;
      x_q           <= x_d;
      y_q           <= y_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      mode_q        <= mode_d;
      pend_mode_q   <= pend_mode_d;
      pend_valid_q  <= pend_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_bar_q     <= pix_bar_d;
      pix_mode_q    <= mode_q;
      rgb_q         <= rgb_d;
      x_out_q       <= pix_x_q;
      y_out_q       <= pix_y_q;
    end
  end

  vga_delay_line #(
    .DEPTH     (2),
    .WIDTH     (3),
    .RESET_VAL (SYNC_BLANK_IDLE)
  ) u_sync_dly (
    .clk   (clk50),
    .rst_n (rst_n),
    .din   ({hsync_in, vsync_in, blank}),
    .dout  ({hsync_dly, vsync_dly, blank_dly})
  );

  assign {vid.red_out, vid.green_out, vid.blue_out} = blank_dly ? RGB_BLACK : rgb_q;
  assign vid.hsync_out       = hsync_dly;
  assign vid.vsync_out       = vsync_dly;
  assign vid.x_out           = x_out_q;
  assign vid.y_out           = y_out_q;
  assign vid.mode_out        = mode_q;
  assign vid.frame_count_out = frame_cnt_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: a scoreboard of expected pixels is
// filled as timing is driven and drained two cycles later.
module tb_test_pattern_gen;

  logic       clk50     = 1'b0;
  logic       rst_n     = 1'b1;
  logic       hsync_in  = 1'b1;
  logic       vsync_in  = 1'b1;
  logic       hblank_in = 1'b1;
  logic       vblank_in = 1'b1;
  logic       mode_next = 1'b0;
  logic       mode_load = 1'b0;
  logic [1:0] mode_sel  = 2'd0;

  test_pattern_gen_if vid ();

  test_pattern_gen dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblank_in (hblank_in),
    .vblank_in (vblank_in),
    .mode_next (mode_next),
    .mode_load (mode_load),
    .mode_sel  (mode_sel),
    .vid       (vid)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [4:0] sig;
    logic [9:0] x;
    logic [9:0] y;
    bit         chk_xy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [1:0] mode_model  = 2'd0;
  logic [7:0] frame_model = 8'd0;
  logic [1:0] pend_m      = 2'd0;
  bit         pend_v      = 1'b0;
  bit         vb_prev     = 1'b1;
  bit         req_next    = 1'b0;
  bit         req_load    = 1'b0;
  logic [1:0] req_sel     = 2'd0;

  function automatic logic [2:0] model_rgb(input int mode, input int p, input int ln);
    int x, y;
    x = (p > 799) ? 799 : p;
    y = (ln > 599) ? 599 : ln;
    case (mode)
      0:       return 3'((p / 100) % 8);
      1:       return (((x / 32) % 2) != ((y / 32) % 2)) ? 3'b111 : 3'b000;
      2:       return ((x % 32) == 0 || (y % 32) == 0) ? 3'b111 : 3'b000;
      default: return 3'(((x / 128) ^ (y / 128)) % 8);
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic hs, input logic vs, input logic hb, input logic vb,
                                input int p, input int ln);
    exp_t       e;
    logic [1:0] req_val;
    @(posedge clk50);
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check_output("sync_rgb",
                   {27'd0, vid.hsync_out, vid.vsync_out, vid.red_out, vid.green_out, vid.blue_out},
                   {27'd0, e.sig});
      if (e.chk_xy)
        check_output("xy", {12'd0, vid.x_out, vid.y_out}, {12'd0, e.x, e.y});
    end
    check_output("mode_frame", {22'd0, vid.mode_out, vid.frame_count_out},
                 {22'd0, mode_model, frame_model});
    hsync_in  = hs;
    vsync_in  = vs;
    hblank_in = hb;
    vblank_in = vb;
    mode_next = req_next;
    mode_load = req_load;
    mode_sel  = req_sel;
    req_val = req_load ? req_sel : mode_model + 2'd1;
    if (vb && !vb_prev) begin
      frame_model = frame_model + 8'd1;
      if (pend_v) begin
        mode_model = pend_m;
        pend_v     = 1'b0;
      end
    end
    if (req_load || req_next) begin
      pend_v = 1'b1;
      pend_m = req_val;
    end
    vb_prev  = vb;
    req_next = 1'b0;
    req_load = 1'b0;
    e.sig    = {hs, vs, (hb || vb) ? 3'b000 : model_rgb(int'(mode_model), p, ln)};
    e.x      = 10'((p > 799) ? 799 : p);
    e.y      = 10'(ln);
    e.chk_xy = !(hb || vb);
    sb.push_back(e);
  endtask

  task automatic run_line(input int n_active, input int ln);
    for (int p = 0; p < n_active; p++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, p, ln);
    for (int i = 0; i < 8; i++) apply_stimulus(!(i >= 2 && i < 5), 1'b1, 1'b1, 1'b0, 0, ln);
  endtask

  task automatic run_vblank(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, !(i >= 1 && i < 3), 1'b1, 1'b1, 0, 0);
  endtask

  task automatic pulse_reset();
    exp_t e;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    hblank_in = 1'b1;
    vblank_in = 1'b1;
    mode_next = 1'b0;
    mode_load = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_output("rst_rgb", {29'd0, vid.red_out, vid.green_out, vid.blue_out}, 32'd0);
    check_output("rst_sync", {30'd0, vid.hsync_out, vid.vsync_out}, 32'd3);
    check_output("rst_xy", {12'd0, vid.x_out, vid.y_out}, 32'd0);
    check_output("rst_mode_frame", {22'd0, vid.mode_out, vid.frame_count_out}, 32'd0);
    repeat (2) @(posedge clk50);
    #1;
    rst_n       = 1'b1;
    mode_model  = 2'd0;
    frame_model = 8'd0;
    pend_v      = 1'b0;
    vb_prev     = 1'b1;
    req_next    = 1'b0;
    req_load    = 1'b0;
    sb.delete();
    e.sig    = 5'b11000;
    e.x      = '0;
    e.y      = '0;
    e.chk_xy = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
  endtask

  initial begin
    #5;
    pulse_reset();
    run_vblank(8);

    // Bars frame with a mode_next mid-frame; second line overruns the active width.
    run_line(800, 0);
    req_next = 1'b1;
    run_line(810, 1);
    run_line(5, 2);
    run_vblank(6);

    // Checker frame; simultaneous next and load, load must win.
    for (int l = 0; l < 40; l++) begin
      if (l == 20) begin
        req_next = 1'b1;
        req_load = 1'b1;
        req_sel  = 2'd3;
      end
      run_line(70, l);
    end
    run_vblank(6);

    // Ramp frame, reset lands at pixel (400,300) with a pending mode.
    run_line(800, 0);
    req_load = 1'b1;
    req_sel  = 2'd2;
    for (int l = 1; l < 300; l++) run_line(2, l);
    for (int p = 0; p <= 400; p++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, p, 300);
    pulse_reset();
    run_vblank(4);
    run_line(40, 0);
    run_vblank(4);

    // Newer request overwrites the older pending one.
    run_line(40, 0);
    req_load = 1'b1;
    req_sel  = 2'd1;
    run_line(40, 1);
    req_load = 1'b1;
    req_sel  = 2'd2;
    run_line(40, 2);
    run_vblank(6);

    // Grid frame; a request on the vblank edge cycle waits one more frame.
    for (int l = 0; l < 40; l++) begin
      if (l == 30) begin
        req_load = 1'b1;
        req_sel  = 2'd1;
      end
      run_line(70, l);
    end
    req_load = 1'b1;
    req_sel  = 2'd3;
    run_vblank(6);
    run_line(40, 0);
    run_vblank(4);
    run_line(40, 0);

    for (int f = 0; f < 260; f++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
      run_vblank(3);
    end
    run_vblank(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
